// File: rtl/pe_row_ctrl.sv
// Row controller feeding a 3-tap PE: loads weights, streams features, drains results.
// Optional ReLU on captured results when PE_ROW_CTRL_RELU_EN is defined.
module pe_row_ctrl #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int INTERNAL_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_BITS-1:0]     row_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     w_rd,
  output logic [1:0]               w_addr,
  input  logic [DATA_BITS-1:0]     w_rdata,
  output logic                     if_rd,
  output logic [ADDR_BITS-1:0]     if_addr,
  input  logic [DATA_BITS-1:0]     if_rdata,
  output logic                     pe_W_w,
  output logic [DATA_BITS-1:0]     pe_W_in,
  output logic                     pe_IF_w,
  output logic [DATA_BITS-1:0]     pe_IF_in,
  input  logic [INTERNAL_BITS-1:0] pe_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INTERNAL_BITS-1:0] out_data,
  output logic [ADDR_BITS-1:0]     out_idx
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    FETCH,
    SHIFT,
    CAPTURE,
    DONE
  } state_t;

  state_t                 state, state_n;
  logic [ADDR_BITS-1:0]   k, k_n;
  logic [ADDR_BITS-1:0]   len_q;
  logic [1:0]             cnt, cnt_n;
  logic                   err_q;
  logic                   accept;
  logic                   short_req;
  logic                   cap_ld;
  logic [INTERNAL_BITS-1:0] cap_val;

  assign accept    = (state == IDLE) && start && (row_len >= ADDR_BITS'(3));
  assign short_req = (state == IDLE) && start && (row_len <  ADDR_BITS'(3));
  assign cap_ld    = (state == CAPTURE) && (!out_valid || out_ready);
  assign err       = err_q;

  // Result shaping before capture
  always_comb begin
`ifdef PE_ROW_CTRL_RELU_EN
    cap_val = pe_result[INTERNAL_BITS-1] ? '0 : pe_result;
`else
    cap_val = pe_result;
`endif
  end

  // FSM state, tap index, load counter, latched length and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      cnt   <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      k     <= k_n;
      cnt   <= cnt_n;
      err_q <= short_req;
      if (accept) len_q <= row_len;
    end
  end

  // Output register: loads on capture, clears when drained
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (cap_ld) begin
      out_valid <= 1'b1;
      out_data  <= cap_val;
      out_idx   <= k - ADDR_BITS'(2);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Next-state and strobe/bus decode
  always_comb begin
    state_n  = state;
    k_n      = k;
    cnt_n    = cnt;
    busy     = (state != IDLE);
    done     = err_q;
    w_rd     = 1'b0;
    w_addr   = '0;
    pe_W_w   = 1'b0;
    pe_W_in  = '0;
    if_rd    = 1'b0;
    if_addr  = '0;
    pe_IF_w  = 1'b0;
    pe_IF_in = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = LOAD_W;
          k_n     = '0;
          cnt_n   = '0;
        end
      end
      LOAD_W: begin
        if (cnt != 2'd3) begin
          w_rd   = 1'b1;
          w_addr = cnt;
        end
        if (cnt != 2'd0) begin
          pe_W_w  = 1'b1;
          pe_W_in = w_rdata;
        end
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) state_n = FETCH;
      end
      FETCH: begin
        if_rd   = 1'b1;
        if_addr = k;
        state_n = SHIFT;
      end
      SHIFT: begin
        pe_IF_w  = 1'b1;
        pe_IF_in = if_rdata;
        if (k < ADDR_BITS'(2)) begin
          k_n     = k + ADDR_BITS'(1);
          state_n = FETCH;
        end else begin
          state_n = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cap_ld) begin
          if (k == len_q - ADDR_BITS'(1)) begin
            state_n = DONE;
          end else begin
            k_n     = k + ADDR_BITS'(1);
            state_n = FETCH;
          end
        end
      end
      DONE: begin
        if (!out_valid) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Scoreboard bench for pe_row_ctrl with behavioural memories and 3-tap PE.
// Expected results come from a reference convolution over the bench memories.
module tb_pe_row_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  row_len;
  logic        busy, done, err;
  logic        w_rd;
  logic [1:0]  w_addr;
  logic [15:0] w_rdata;
  logic        if_rd;
  logic [7:0]  if_addr;
  logic [15:0] if_rdata;
  logic        pe_W_w, pe_IF_w;
  logic [15:0] pe_W_in, pe_IF_in;
  logic [31:0] pe_result;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_idx;

  pe_row_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .busy(busy), .done(done), .err(err),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .if_rd(if_rd), .if_addr(if_addr), .if_rdata(if_rdata),
    .pe_W_w(pe_W_w), .pe_W_in(pe_W_in),
    .pe_IF_w(pe_IF_w), .pe_IF_in(pe_IF_in), .pe_result(pe_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] w_mem [4];
  logic [15:0] f_mem [256];

  // Memories with one-cycle read latency
  always @(posedge clk) begin
    w_rdata  <= w_rd  ? w_mem[w_addr]  : 16'h0;
    if_rdata <= if_rd ? f_mem[if_addr] : 16'h0;
  end

  logic signed [15:0] wr0 = 0, wr1 = 0, wr2 = 0;
  logic signed [15:0] fr0 = 0, fr1 = 0, fr2 = 0;
  logic signed [31:0] pe_s;

  // PE: shift registers, oldest entry at tap 0
  always @(posedge clk) begin
    if (pe_W_w) begin
      wr0 <= wr1; wr1 <= wr2; wr2 <= pe_W_in;
    end
    if (pe_IF_w) begin
      fr0 <= fr1; fr1 <= fr2; fr2 <= pe_IF_in;
    end
  end
  assign pe_s = wr0 * fr0 + wr1 * fr1 + wr2 * fr2;
  assign pe_result = pe_s;

  int n_wrd = 0, n_ifrd = 0, n_ww = 0, n_ifw = 0;
  int n_done = 0, n_err = 0, n_bus = 0, n_xfer = 0;

  // Activity counters sampled mid-cycle
  always @(negedge clk) begin
    if (w_rd) n_wrd++;
    if (if_rd) n_ifrd++;
    if (pe_W_w) n_ww++;
    if (pe_IF_w) n_ifw++;
    if (done) n_done++;
    if (err) n_err++;
    if (out_valid && out_ready) n_xfer++;
    if ((!w_rd && w_addr != 0) || (!if_rd && if_addr != 0) ||
        (!pe_W_w && pe_W_in != 0) || (!pe_IF_w && pe_IF_in != 0))
      n_bus++;
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit abort = 0;
  logic [39:0] exp_q [$];

  function automatic logic [31:0] model(int j);
    int s;
    s = 0;
    for (int t = 0; t < 3; t++)
      s += int'($signed(w_mem[t])) * int'($signed(f_mem[j+t]));
`ifdef PE_ROW_CTRL_RELU_EN
    if (s < 0) s = 0;
`endif
    return 32'(s);
  endfunction

  task automatic load_basic();
    w_mem[0] = 16'd1; w_mem[1] = 16'd2; w_mem[2] = 16'd3;
    for (int i = 0; i < 5; i++) f_mem[i] = 16'(i + 1);
  endtask

  task automatic run_row(input logic [7:0] len, output int cyc, output bit to);
    bit fin;
    logic [39:0] e;
    fin = 0; cyc = 0; to = 0;
    for (int j = 0; j < int'(len) - 2; j++)
      exp_q.push_back({8'(j), model(j)});
    fork
      begin
        row_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!done && !abort && cyc < 400) begin
          @(posedge clk); #1; cyc++;
        end
        to = !done && !abort;
        fin = 1;
      end
      begin
        while (!fin) begin
          @(negedge clk);
          if (!fin && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_bad++;
              $display("FAIL sb_extra: got idx=%0d data=%h, expected none", out_idx, out_data);
            end else begin
              e = exp_q.pop_front();
              if ({out_idx, out_data} !== e) begin
                n_bad++;
                $display("FAIL sb_result: got idx=%0d data=%h, expected idx=%0d data=%h",
                         out_idx, out_data, e[39:32], e[31:0]);
              end
            end
          end
        end
      end
    join
  endtask

  task automatic test_reset();
    logic [99:0] v;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    v = {busy, done, err, w_rd, if_rd, pe_W_w, pe_IF_w, out_valid,
         w_addr, if_addr, pe_W_in, pe_IF_in, out_data, out_idx};
    n_cmp++;
    if (v !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h, expected 0", v);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    int a_wrd, a_ifrd, a_ww, a_ifw, a_done, a_err, a_bus, a_x;
    load_basic();
    a_wrd = n_wrd; a_ifrd = n_ifrd; a_ww = n_ww; a_ifw = n_ifw;
    a_done = n_done; a_err = n_err; a_bus = n_bus; a_x = n_xfer;
    run_row(8'd5, cyc, to);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (to || cyc !== 19) begin
      n_bad++; $display("FAIL basic_latency: got %0d (timeout=%0d), expected 19", cyc, to);
    end
    n_cmp++;
    if (n_xfer - a_x !== 3 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL basic_count: got %0d, expected 3", n_xfer - a_x);
    end
    n_cmp++;
    if (n_wrd - a_wrd !== 3 || n_ww - a_ww !== 3) begin
      n_bad++; $display("FAIL basic_wload: got rd=%0d w=%0d, expected 3/3",
                        n_wrd - a_wrd, n_ww - a_ww);
    end
    n_cmp++;
    if (n_ifrd - a_ifrd !== 5 || n_ifw - a_ifw !== 5) begin
      n_bad++; $display("FAIL basic_fetch: got rd=%0d w=%0d, expected 5/5",
                        n_ifrd - a_ifrd, n_ifw - a_ifw);
    end
    n_cmp++;
    if (n_done - a_done !== 1 || n_err - a_err !== 0) begin
      n_bad++; $display("FAIL basic_done: got done=%0d err=%0d, expected 1/0",
                        n_done - a_done, n_err - a_err);
    end
    n_cmp++;
    if (n_bus - a_bus !== 0) begin
      n_bad++; $display("FAIL bus_idle_zero: got %0d, expected 0", n_bus - a_bus);
    end
  endtask

  task automatic test_relu();
    int cyc; bit to;
    logic [31:0 ] want;
`ifdef PE_ROW_CTRL_RELU_EN
    want = 32'h0;
`else
    want = 32'hFFFF_FFFB;
`endif
    w_mem[0] = 16'hFFFF; w_mem[1] = 16'd0; w_mem[2] = 16'd0;
    f_mem[0] = 16'd5; f_mem[1] = 16'd0; f_mem[2] = 16'd0;
    n_cmp++;
    if (model(0) !== want) begin
      n_bad++; $display("FAIL relu_model: got %h, expected %h", model(0), want);
    end
    run_row(8'd3, cyc, to);
    n_cmp++;
    if (to || exp_q.size() != 0) begin
      n_bad++; $display("FAIL relu_row: got timeout=%0d left=%0d, expected 0/0", to, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int cyc; bit to; int a_ifrd;
    load_basic();
    a_ifrd = n_ifrd;
    fork
      run_row(8'd5, cyc, to);
      begin
        int w;
        w = 0;
        while (!out_valid && w < 100) begin
          @(posedge clk); #1; w++;
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          n_cmp++;
          if (out_valid !== 1'b1 || out_data !== 32'd14 || out_idx !== 8'd0) begin
            n_bad++;
            $display("FAIL stall_hold: cycle %0d got v=%0d d=%0d i=%0d, expected 1/14/0",
                     i, out_valid, out_data, out_idx);
          end
          if (i >= 2) begin
            n_cmp++;
            if (if_rd !== 1'b0 || pe_IF_w !== 1'b0 || pe_W_w !== 1'b0) begin
              n_bad++;
              $display("FAIL stall_quiet: cycle %0d got if_rd=%0d ifw=%0d ww=%0d, expected 0",
                       i, if_rd, pe_IF_w, pe_W_w);
            end
          end
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    n_cmp++;
    if (to || exp_q.size() != 0 || n_ifrd - a_ifrd !== 5) begin
      n_bad++; $display("FAIL stall_row: got timeout=%0d left=%0d ifrd=%0d, expected 0/0/5",
                        to, exp_q.size(), n_ifrd - a_ifrd);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_short();
    int a_wrd, a_ifrd;
    a_wrd = n_wrd; a_ifrd = n_ifrd;
    row_len = 8'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({err, done, busy} !== 3'b110) begin
      n_bad++; $display("FAIL short_pulse: got err/done/busy=%b, expected 110", {err, done, busy});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({err, done, busy} !== 3'b000) begin
      n_bad++; $display("FAIL short_after: got err/done/busy=%b, expected 000", {err, done, busy});
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (n_wrd - a_wrd !== 0 || n_ifrd - a_ifrd !== 0) begin
      n_bad++; $display("FAIL short_noread: got w=%0d f=%0d, expected 0/0",
                        n_wrd - a_wrd, n_ifrd - a_ifrd);
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit to; int a_done;
    logic [99:0] v;
    load_basic();
    a_done = n_done;
    fork
      run_row(8'd5, cyc, to);
      begin
        int w;
        w = 0;
        while (!(if_rd && if_addr == 8'd3) && w < 200) begin
          @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (pe_IF_w !== 1'b1) begin
          n_bad++; $display("FAIL mid_in_shift: got pe_IF_w=%0d, expected 1", pe_IF_w);
        end
        rst = 1'b1; abort = 1;
        @(posedge clk); #1;
        v = {busy, done, err, w_rd, if_rd, pe_W_w, pe_IF_w, out_valid,
             w_addr, if_addr, pe_W_in, pe_IF_in, out_data, out_idx};
        n_cmp++;
        if (v !== '0) begin
          n_bad++; $display("FAIL mid_reset_state: got %h, expected 0", v);
        end
        rst = 1'b0;
      end
    join
    exp_q.delete();
    abort = 0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (n_done - a_done !== 0) begin
      n_bad++; $display("FAIL mid_no_done: got %0d, expected 0", n_done - a_done);
    end
    run_row(8'd5, cyc, to);
    n_cmp++;
    if (to || cyc !== 19 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL mid_rerun: got cyc=%0d left=%0d, expected 19/0", cyc, exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; int a_done, a_err, a_x;
    load_basic();
    a_done = n_done; a_err = n_err; a_x = n_xfer;
    fork
      run_row(8'd5, cyc, to);
      begin
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; row_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; row_len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (to || n_done - a_done !== 1 || n_err - a_err !== 0) begin
      n_bad++; $display("FAIL busy_start_done: got done=%0d err=%0d, expected 1/0",
                        n_done - a_done, n_err - a_err);
    end
    n_cmp++;
    if (n_xfer - a_x !== 3 || exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_count: got %0d busy=%0d, expected 3/0",
                        n_xfer - a_x, busy);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row_len = 8'd0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) w_mem[i] = 16'h0;
    for (int i = 0; i < 256; i++) f_mem[i] = 16'h0;
    test_reset();
    test_basic();
    test_relu();
    test_stall();
    test_short();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
